// File: rtl/mp_pkg.sv
// -----------------------------------------------------------------------------
// mp_pkg
// Shared definitions for the MP output scheduler: scheduler state encoding,
// MP data width, counter width and the width of source indices.
// No ports (package).
// -----------------------------------------------------------------------------
package mp_pkg;

  localparam int MP_W  = 8;   // width of one source's MP data slice
  localparam int CNT_W = 16;  // settle / burst / guard counter width
  localparam int IDX_W = 3;   // source index width (up to 8 sources)

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2,
    GUARD  = 2'd3
  } state_e;

endpackage

// File: rtl/mp_out_sched_if.sv
// -----------------------------------------------------------------------------
// mp_out_sched_if
// Bundles the source-side request/data/clock signals and the scheduled
// channel outputs of mp_out_sched.
//   req     : per-source request level
//   mp_in   : packed source data, source i in bits [8i+7:8i]
//   clk_in  : per-source clock to forward
//   grant   : one-hot grant, zero when no owner
//   clk_out : forwarded clock of the owner while ACTIVE
//   mp_out  : owner's data slice while ACTIVE, else zero
//   active  : high exactly while the owner is connected
//   owner   : index of the current or last owner
// Modports: master = source/board side, slave = scheduler.
// -----------------------------------------------------------------------------
interface mp_out_sched_if #(
  parameter int N_SRC = 4
) ();
  import mp_pkg::*;

  logic [N_SRC-1:0]       req;
  logic [MP_W*N_SRC-1:0]  mp_in;
  logic [N_SRC-1:0]       clk_in;
  logic [N_SRC-1:0]       grant;
  logic                   clk_out;
  logic [MP_W-1:0]        mp_out;
  logic                   active;
  logic [IDX_W-1:0]       owner;

  modport master (
    output req, mp_in, clk_in,
    input  grant, clk_out, mp_out, active, owner
  );

  modport slave (
    input  req, mp_in, clk_in,
    output grant, clk_out, mp_out, active, owner
  );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans req starting at ptr+1 and wrapping,
// returning the first requesting source.
//   req_i    : request vector
//   ptr_i    : last served source; it is ranked last in the scan
//   onehot_o : one-hot winner (zero when nobody requests)
//   idx_o    : winner index
//   valid_o  : at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import mp_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_SRC-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  int   cand_s;
  logic hit_s;

  // Scan candidates in priority order; the first requesting one wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand_s   = 0;
    hit_s    = 1'b0;
    for (int j = 0; j < N_SRC; j++) begin
      cand_s = (int'(ptr_i) + 1 + j) % N_SRC;
      // Select req_i[cand_s] by comparison to keep index widths exact.
      hit_s = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
        if (i == cand_s) begin
          hit_s = req_i[i];
        end else begin
          hit_s = hit_s;
        end
      end
      if (hit_s && !valid_o) begin
        valid_o  = 1'b1;
        idx_o    = IDX_W'(cand_s);
        onehot_o = ONE << cand_s;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/mp_out_sched.sv
// -----------------------------------------------------------------------------
// mp_out_sched
// Time-shares the single MP output channel among N_SRC sources. Grants are
// round-robin; each grant passes through SETTLE (channel forced to zero),
// ACTIVE (owner's data and clock forwarded, bounded by MAX_BURST) and GUARD
// (channel forced to zero) before the next arbitration in IDLE.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : scheduler side of mp_out_sched_if (requests, data, outputs)
// -----------------------------------------------------------------------------
module mp_out_sched
  import mp_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int SETTLE_CYC = 255,
  parameter int MAX_BURST  = 1024,
  parameter int GUARD_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  mp_out_sched_if.slave     bus
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              active_q, active_d;

  logic [N_SRC-1:0]  pick_onehot_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic              pick_valid_s;

  logic              own_req_s;
  logic              own_clk_s;
  logic [MP_W-1:0]   own_mp_s;

  rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot_s),
    .idx_o    (pick_idx_s),
    .valid_o  (pick_valid_s)
  );

  // Select the owner's request, clock and data slice.
  always_comb begin
    own_req_s = 1'b0;
    own_clk_s = 1'b0;
    own_mp_s  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_req_s = bus.req[i];
        own_clk_s = bus.clk_in[i];
        own_mp_s  = bus.mp_in[i*MP_W +: MP_W];
      end else begin
        own_req_s = own_req_s;
      end
    end
  end

  // Next-state logic for the grant sequence IDLE -> SETTLE -> ACTIVE -> GUARD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          grant_d = pick_onehot_s;
          owner_d = pick_idx_s;
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        // A dropped request aborts the grant before it ever goes ACTIVE.
        if (!own_req_s) begin
          state_d = GUARD;
          grant_d = '0;
          ptr_d   = owner_q;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ACTIVE: begin
        if (!own_req_s || (cnt_q == BURST_LAST)) begin
          state_d = GUARD;
          grant_d = '0;
          ptr_d   = owner_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
    active_d = (state_d == ACTIVE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= IDX_W'(N_SRC - 1);
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.active  = active_q;
  assign bus.owner   = owner_q;
  // Data and clock are gated combinationally so the owner's stream passes unregistered.
  assign bus.mp_out  = active_q ? own_mp_s : '0;
  assign bus.clk_out = active_q & own_clk_s;

endmodule

// File: tb/tb_mp_out_sched.sv
module tb_mp_out_sched;
  import mp_pkg::*;

  localparam int N = 4;
  localparam int S = 255;
  localparam int B = 1024;
  localparam int G = 2;
  localparam int VW = N + 13;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mp_out_sched_if #(.N_SRC(N)) bus ();

  mp_out_sched #(.N_SRC(N), .SETTLE_CYC(S), .MAX_BURST(B), .GUARD_CYC(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: time-stamped ownership instead of counters.
  int n      = 0;   // rising edges seen
  bit m_busy = 1'b0;
  int m_own  = 0;
  int m_t0   = 0;   // edge at which the current grant was issued
  int m_last = N - 1;
  int m_free = 0;   // first edge at which requests may be evaluated

  task automatic model_edge(input logic [N-1:0] r, input logic rv);
    if (rv) begin
      m_busy = 1'b0; m_own = 0; m_last = N - 1; m_free = n + 1;
    end else if (m_busy) begin
      if (r[m_own] == 1'b0 || n == m_t0 + S + B) begin
        m_busy = 1'b0; m_last = m_own; m_free = n + G + 1;
      end
    end else if (n >= m_free && r != '0) begin
      for (int k = 1; k <= N; k++) begin
        if (!m_busy && r[(m_last + k) % N]) begin
          m_busy = 1'b1; m_own = (m_last + k) % N; m_t0 = n;
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic act; logic [N-1:0] g; logic [7:0] mp; logic ck;
    act = m_busy && (n >= m_t0 + S);
    g   = m_busy ? (N'(1) << m_own) : '0;
    mp  = act ? bus.mp_in[m_own*8 +: 8] : 8'h00;
    ck  = act ? bus.clk_in[m_own] : 1'b0;
    return {g, act, 3'(m_own), mp, ck};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.grant, bus.active, bus.owner, bus.mp_out, bus.clk_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    n++;
    model_edge(bus.req, rst);
    #2;
  endtask

  task automatic rand_data();
    bus.mp_in  = $urandom;
    bus.clk_in = 4'($urandom_range(0, 15));
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 4'b1111; rand_data();
    tick(); tick(); rand_data();
    checks++;
    if (obs_vec() !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h want 0", obs_vec());
    end
    rst = 1'b0; bus.req = 4'b0000; tick(); rand_data();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_first_grant_and_burst();
    int start, g_at, a_first, a_cnt, gap, regrant;
    do_reset();
    start = n; g_at = -1; a_first = -1; a_cnt = 0; gap = 0; regrant = -1;
    bus.req = 4'b0001;
    for (int c = 0; c < 1400 && regrant < 0; c++) begin
      tick(); rand_data();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL burst_cycle %0d: got %h want %h", n - start, obs_vec(), exp_vec());
      end
      if (g_at < 0 && bus.grant == 4'b0001) g_at = n - start;
      if (bus.active) begin
        if (a_first < 0) a_first = n - start;
        a_cnt++;
      end
      if (a_cnt > 0 && bus.grant == 4'b0000) gap++;
      if (gap > 0 && bus.grant == 4'b0001) regrant = n - start;
    end
    checks++;
    if (g_at !== 1) begin failures++; $display("FAIL grant_latency: got %0d want 1", g_at); end
    checks++;
    if (a_first !== 256) begin failures++; $display("FAIL settle_len: active at %0d want 256", a_first); end
    checks++;
    if (a_cnt !== B) begin failures++; $display("FAIL burst_len: got %0d want %0d", a_cnt, B); end
    checks++;
    if (gap !== G + 1) begin failures++; $display("FAIL guard_gap: got %0d want %0d", gap, G + 1); end
    checks++;
    if (regrant !== 1 + S + B + G + 1) begin
      failures++; $display("FAIL regrant: got %0d want %0d", regrant, 1 + S + B + G + 1);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [3:0] rr_exp [5];
    logic [3:0] seen_g [5];
    int         seen_o [5];
    int got;
    logic [3:0] prev;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    bus.req = 4'b1111; got = 0; prev = 4'b0000;
    for (int c = 0; c < 7000 && got < 5; c++) begin
      tick(); rand_data();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL rr_cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (prev == 4'b0000 && bus.grant != 4'b0000) begin
        seen_g[got] = bus.grant; seen_o[got] = int'(bus.owner); got++;
      end
      prev = bus.grant;
    end
    checks++;
    if (got !== 5) begin failures++; $display("FAIL rr_count: got %0d want 5", got); end
    for (int k = 0; k < got; k++) begin
      checks++;
      if (seen_g[k] !== rr_exp[k] || seen_o[k] !== k % N) begin
        failures++;
        $display("FAIL rr_order[%0d]: got grant %b owner %0d want grant %b owner %0d",
                 k, seen_g[k], seen_o[k], rr_exp[k], k % N);
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_abort();
    int rel, regrant;
    bit act_seen, clk_seen;
    do_reset();
    bus.req = 4'b0100; act_seen = 1'b0; clk_seen = 1'b0; regrant = -1;
    for (int c = 0; c < 101; c++) begin
      tick(); rand_data();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL abort_settle %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      act_seen |= bus.active; clk_seen |= bus.clk_out;
    end
    bus.req = 4'b0000;
    tick(); rand_data(); rel = n;
    checks++;
    if (bus.grant !== 4'b0000) begin failures++; $display("FAIL abort_release: got %b want 0000", bus.grant); end
    bus.req = 4'b0100;
    for (int c = 0; c < 20 && regrant < 0; c++) begin
      tick(); rand_data();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL abort_guard %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      act_seen |= bus.active; clk_seen |= bus.clk_out;
      if (bus.grant == 4'b0100) regrant = n - rel;
    end
    checks++;
    if (act_seen !== 1'b0) begin failures++; $display("FAIL abort_active: got 1 want 0"); end
    checks++;
    if (clk_seen !== 1'b0) begin failures++; $display("FAIL abort_clk: got 1 want 0"); end
    checks++;
    if (regrant !== G + 1) begin failures++; $display("FAIL abort_regrant: got %0d want %0d", regrant, G + 1); end
    bus.req = 4'b0000;
  endtask

  task automatic test_isolation();
    int c;
    do_reset();
    bus.req = 4'b0010; c = 0;
    while (!bus.active && c < 400) begin tick(); rand_data(); c++; end
    checks++;
    if (bus.active !== 1'b1) begin failures++; $display("FAIL iso_wait: active got %b want 1", bus.active); end
    for (int k = 0; k < 64; k++) begin
      tick();
      bus.mp_in  = $urandom;
      bus.clk_in = {2'($urandom_range(0, 3)), 1'(k), 1'($urandom_range(0, 1))};
      #1;
      checks++;
      if (bus.mp_out !== bus.mp_in[15:8] || bus.clk_out !== bus.clk_in[1]) begin
        failures++;
        $display("FAIL iso_%0d: got mp %h clk %b want mp %h clk %b",
                 k, bus.mp_out, bus.clk_out, bus.mp_in[15:8], bus.clk_in[1]);
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_rst_mid_burst();
    int c;
    do_reset();
    bus.req = 4'b1000; c = 0;
    while (!bus.active && c < 400) begin tick(); rand_data(); c++; end
    checks++;
    if (bus.active !== 1'b1 || bus.owner !== 3'd3) begin
      failures++; $display("FAIL rst_wait: active %b owner %0d want 1 3", bus.active, bus.owner);
    end
    for (int k = 0; k < 49; k++) begin tick(); bus.clk_in = 4'b1111; bus.mp_in = 32'hFFFF_FFFF; #1; end
    rst = 1'b1; bus.req = 4'b1111;
    tick(); #1;
    checks++;
    if ({bus.grant, bus.active, bus.mp_out, bus.clk_out} !== '0) begin
      failures++; $display("FAIL rst_mid: got %b %b %h %b want all 0", bus.grant, bus.active, bus.mp_out, bus.clk_out);
    end
    rst = 1'b0;
    tick(); #1;
    checks++;
    if (bus.grant !== 4'b0001 || bus.owner !== 3'd0) begin
      failures++; $display("FAIL rst_ptr: got grant %b owner %0d want 0001 0", bus.grant, bus.owner);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_random();
    do_reset();
    bus.req = 4'($urandom_range(0, 15));
    for (int c = 0; c < 15000; c++) begin
      rst = ($urandom_range(0, 4999) == 0);
      tick();
      if ($urandom_range(0, 99) < 2) bus.req[$urandom_range(0, N - 1)] ^= 1'b1;
      rand_data();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.req = '0; bus.mp_in = '0; bus.clk_in = '0;
    test_reset();
    test_first_grant_and_burst();
    test_round_robin();
    test_abort();
    test_isolation();
    test_rst_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
